// File: rtl/num_pkg.sv
// Shared types and default timing constants for the num_stepper source stage.
package num_pkg;

  localparam int unsigned NUM_W               = 5;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;
  localparam int unsigned SCAN_DIV_DEF        = 50000000;

  typedef logic [NUM_W-1:0] num_t;

  typedef enum logic {MANUAL, AUTO} step_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and a one-cycle press pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic             sync1;
  logic             sync2;
  logic             state;
  logic             armed;
  logic [CNT_W-1:0] cnt;

  logic mismatch_c;
  logic arm_wait_c;
  logic counting_c;
  logic done_c;

  // Until a released level has been confirmed after reset, a held button may
  // settle the debounced state high but never produces a press.
  assign mismatch_c = (sync2 != state);
  assign arm_wait_c = !armed && !state && !sync2;
  assign counting_c = mismatch_c || arm_wait_c;
  assign done_c     = counting_c && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      state <= 1'b0;
      armed <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (!counting_c) begin
        cnt <= '0;
      end else if (done_c) begin
        cnt   <= '0;
        state <= sync2;
        if (sync2) press <= armed;
        else       armed <= 1'b1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/num_stepper.sv
// Operator-driven 5-bit value source: step/load by buttons or auto-scan 0..31.
// Define NUM_SATURATE_EN to clamp at 0/31 instead of wrapping.
module num_stepper
  import num_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned SCAN_DIV        = SCAN_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_up,
  input  logic             btn_dn,
  input  logic             btn_load,
  input  logic [NUM_W-1:0] sw,
  input  logic             auto_mode,
  output logic [NUM_W-1:0] num,
  output logic             num_changed
);

  localparam int unsigned PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  step_state_t        state;
  step_state_t        state_d;
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] presc_d;
  num_t               num_d;
  num_t               num_inc;
  num_t               num_dec;
  logic               up_p;
  logic               dn_p;
  logic               load_p;
  logic               auto_s1;
  logic               auto_s2;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk(clk), .rst_n(rst_n), .btn(btn_up), .press(up_p)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
    .clk(clk), .rst_n(rst_n), .btn(btn_dn), .press(dn_p)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
    .clk(clk), .rst_n(rst_n), .btn(btn_load), .press(load_p)
  );

`ifdef NUM_SATURATE_EN
  assign num_inc = (num == '1) ? num : num + num_t'(1);
  assign num_dec = (num == '0) ? num : num - num_t'(1);
`else
  assign num_inc = num + num_t'(1);
  assign num_dec = num - num_t'(1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_s1     <= 1'b0;
      auto_s2     <= 1'b0;
      state       <= MANUAL;
      presc       <= '0;
      num         <= '0;
      num_changed <= 1'b0;
    end else begin
      auto_s1     <= auto_mode;
      auto_s2     <= auto_s1;
      state       <= state_d;
      presc       <= presc_d;
      num         <= num_d;
      num_changed <= (num_d != num);
    end
  end

  // Mode selection and value update; load always wins over a scan step.
  always_comb begin
    state_d = state;
    num_d   = num;
    presc_d = presc;
    case (state)
      MANUAL: begin
        if (load_p)             num_d = sw;
        else if (up_p && !dn_p) num_d = num_inc;
        else if (dn_p && !up_p) num_d = num_dec;
        if (auto_s2) begin
          state_d = AUTO;
          presc_d = '0;
        end
      end
      AUTO: begin
        if (load_p) begin
          num_d   = sw;
          presc_d = '0;
        end else if (presc == PRESC_W'(SCAN_DIV - 1)) begin
          num_d   = num_inc;
          presc_d = '0;
        end else begin
          presc_d = presc + PRESC_W'(1);
        end
        if (!auto_s2) begin
          state_d = MANUAL;
          presc_d = '0;
        end
      end
    endcase
  end

endmodule

// File: doc/num_stepper.md
Name: num_stepper

Overview:
- Upstream source stage for the 5-bit number-property detector; produces the registered 5-bit `num` that the detector classifies onto LEDs.
- Operator steps the value up or down with push-buttons, loads it from slide switches, or lets it auto-scan through 0..31.
- All button inputs are synchronised and debounced inside the block.

Parameters:
- NUM_W, 5, width of `num`; fixed by the downstream detector.
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised cycles before a button state is accepted (10 ms at 100 MHz).
- SCAN_DIV, 50000000, clock cycles between auto-scan steps (0.5 s at 100 MHz).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- btn_up  in  1  raw push-button, increment
- btn_dn  in  1  raw push-button, decrement
- btn_load  in  1  raw push-button, load from `sw`
- sw  in  NUM_W  raw slide switches, load value
- auto_mode  in  1  raw switch; 1 selects auto-scan
- num  out  NUM_W  current value, registered; feeds the detector
- num_changed  out  1  one-cycle pulse, coincident with each new `num` value

Behaviour:
- One clock domain, `clk`. Reset is asynchronous and active-low on `rst_n`.
- Reset values: num=0, num_changed=0, state=MANUAL. All synchroniser flops, debounced states, debounce counters and the prescaler are 0.
- Synchronisation: 2-flop synchroniser on btn_up, btn_dn, btn_load and auto_mode. sw is sampled only when a load is taken; no synchroniser on sw.
- Debounce, per button:
  - Counter increments while the synchronised value differs from the debounced state; it clears to 0 whenever they match.
  - On the cycle the counter reaches DEBOUNCE_CYCLES-1 while still mismatched, the debounced state takes the new value and the counter clears.
  - A press pulse is high for exactly one cycle after the debounced state rises 0->1. Release generates nothing.
- Latency: with a clean press, `num` updates on the (DEBOUNCE_CYCLES+3)th rising edge, counting the first edge that samples the button high as edge 1.
- A glitch shorter than DEBOUNCE_CYCLES cycles causes no change.
- FSM states:
  - MANUAL->AUTO when synchronised auto_mode=1. Prescaler clears on entry.
  - AUTO->MANUAL when synchronised auto_mode=0. Prescaler clears.
- MANUAL:
  - load pulse: num<=sw.
  - else up pulse without dn pulse: num<=num+1.
  - else dn pulse without up pulse: num<=num-1.
  - Simultaneous up and dn pulses: no change.
- AUTO:
  - Prescaler counts 0..SCAN_DIV-1. At terminal count, num<=num+1 and the prescaler clears. The first step occurs SCAN_DIV cycles after entry.
  - up and dn pulses are ignored.
  - load pulse: num<=sw and the prescaler clears. Load has priority over a coincident scan step.
- Arithmetic: modulo 2^NUM_W (31+1=0, 0-1=31) unless NUM_SATURATE_EN is defined.
- num_changed: registered; high exactly in the cycle `num` first shows a new value. A load of a value equal to the current `num` gives no pulse.
- Reset mid-debounce or mid-scan: everything returns to reset values immediately. No press pulse is generated after reset releases while a button is still held, until it has been released and pressed again, because the debounced state must first return to 0.

Optional Feature:
- Macro: NUM_SATURATE_EN.
- Defined:
  - up at 31 holds 31; dn at 0 holds 0.
  - Auto-scan stops advancing at 31; the prescaler keeps running.
  - No num_changed pulse when the value is held.
- Undefined: wrap-around as above.

Decomposition:
- Package num_pkg:
  - localparam NUM_W=5.
  - typedef logic [NUM_W-1:0] num_t.
  - typedef enum logic {MANUAL, AUTO} step_state_t.
  - Default DEBOUNCE_CYCLES and SCAN_DIV constants.
- Sub-module btn_debounce (2-flop sync, debounce counter, rising-edge press pulse; parameter DEBOUNCE_CYCLES), instantiated three times.
- auto_mode uses a plain 2-flop synchroniser in the top level.

Test Plan (DEBOUNCE_CYCLES=4, SCAN_DIV=8):
1. Reset, then one clean btn_up press held 20 cycles -> num 0->1 on edge 7 after the first high sample; num_changed high that single cycle; release causes no further change.
2. num=31, btn_up press -> num=0 with a num_changed pulse. num=0, btn_dn press -> num=31. With NUM_SATURATE_EN: 31 holds, 0 holds, no pulse.
3. btn_up high for 3 cycles then low -> num unchanged, no pulse. btn_up and btn_dn pressed on the same cycle -> num unchanged.
4. sw=5'd22, btn_load press -> num=22 and pulse. Load again with sw=5'd22 -> no pulse.
5. auto_mode=1 from num=29 -> num 30, 31, 0 at 8-cycle intervals after entry. A load of sw=3 on the same cycle as a scan step -> num=3; next step 8 cycles later gives 4. btn_up during AUTO is ignored.
6. Assert rst_n low mid-scan and mid-debounce -> num=0 and num_changed=0 asynchronously. Release with btn_up still held -> no increment until the button is released and pressed again.
